// File: rtl/conv_sched_pkg.sv
// conv_sched shared types: one-hot state encoding, error codes
// and default guard/watchdog settings.
package conv_sched_pkg;

   localparam int GUARD_DEF   = 2;
   localparam int TIMEOUT_DEF = 4096;

   localparam int I_IDLE  = 0;
   localparam int I_LOAD  = 1;
   localparam int I_CONV  = 2;
   localparam int I_DRAIN = 3;
   localparam int I_WB    = 4;
   localparam int I_DONE  = 5;
   localparam int I_ERR   = 6;

   typedef enum logic [6:0] {
      S_IDLE  = 7'b000_0001,
      S_LOAD  = 7'b000_0010,
      S_CONV  = 7'b000_0100,
      S_DRAIN = 7'b000_1000,
      S_WB    = 7'b001_0000,
      S_DONE  = 7'b010_0000,
      S_ERR   = 7'b100_0000
   } state_t;

   typedef logic [1:0] ec_t;

   localparam ec_t EC_ABORT = 2'b00;
   localparam ec_t EC_LOAD  = 2'b01;
   localparam ec_t EC_CONV  = 2'b10;
   localparam ec_t EC_WB    = 2'b11;

endpackage

// File: rtl/conv_sched_if.sv
// conv_sched host, engine and DMA handshake bundle.
// master = scheduler side, slave = host/engine/DMA side.
interface conv_sched_if
   import conv_sched_pkg::*;
#(
   parameter int TILE_W = 8
);
   logic              start;
   logic              abort;
   logic [TILE_W-1:0] num_tiles;
   logic              busy;
   logic              job_done;
   logic              err;
   ec_t               err_code;
   logic [TILE_W-1:0] tile_idx;
   logic              ld_req;
   logic              ld_ack;
   logic              conv_en;
   logic              conv_done;
   logic              wb_req;
   logic              wb_ack;

   modport master (
      input  start, abort, num_tiles,
      input  ld_ack, conv_done, wb_ack,
      output busy, job_done, err, err_code,
      output tile_idx, ld_req, conv_en, wb_req
   );

   modport slave (
      output start, abort, num_tiles,
      output ld_ack, conv_done, wb_ack,
      input  busy, job_done, err, err_code,
      input  tile_idx, ld_req, conv_en, wb_req
   );

endinterface

// File: rtl/sched_wdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear
// and flags the cycle in which the count reaches TIMEOUT-1.
module sched_wdog #(
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + TO_W'(1);
      end
   end

   assign expired = en && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/conv_sched.sv
// Job-level sequencer: per tile LOAD -> CONV -> DRAIN -> WB,
// with abort, per-phase watchdog and sticky error status.
module conv_sched
   import conv_sched_pkg::*;
#(
   parameter int TILE_W  = 8,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int GUARD   = GUARD_DEF
) (
   input logic          clk,
   input logic          rstn,
   conv_sched_if.master bus
);

   localparam int GW = $clog2(GUARD + 2);

   state_t            state;
   state_t            state_n;
   ec_t               ec_n;
   ec_t               err_code_r;
   logic [TILE_W-1:0] num_lat;
   logic [TILE_W-1:0] tile_idx_r;
   logic [GW-1:0]     gcnt;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic              ld_r;
   logic              conv_r;
   logic              wb_r;
   logic              load_job;
   logic              idx_inc;
   logic              set_err;
   logic              wd_clr;
   logic              wd_en;
   logic              expired;
   logic              guard_ok;
   logic              last;

   assign guard_ok = gcnt >= GW'(GUARD);
   assign last     = tile_idx_r == num_lat - TILE_W'(1);
   assign wd_en    = state[I_LOAD] | state[I_CONV] | state[I_WB];
   assign wd_clr   = state_n != state;
   assign set_err  = state_n == S_ERR;

   sched_wdog #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (expired)
   );

   always_comb begin
      state_n  = state;
      ec_n     = EC_ABORT;
      load_job = 1'b0;
      idx_inc  = 1'b0;
      unique case (1'b1)
         state[I_IDLE]: begin
            if (bus.start) begin
               load_job = 1'b1;
               state_n  = (bus.num_tiles == '0) ? S_DONE : S_LOAD;
            end
         end
         state[I_LOAD]: begin
            if (bus.abort) begin
               state_n = S_ERR;
            end else if (bus.ld_ack) begin
               state_n = S_CONV;
            end else if (expired) begin
               state_n = S_ERR;
               ec_n    = EC_LOAD;
            end
         end
         state[I_CONV]: begin
            if (bus.abort) begin
               state_n = S_ERR;
            end else if (bus.conv_done && guard_ok) begin
               state_n = S_DRAIN;
            end else if (expired) begin
               state_n = S_ERR;
               ec_n    = EC_CONV;
            end
         end
         state[I_DRAIN]: begin
            state_n = bus.abort ? S_ERR : S_WB;
         end
         state[I_WB]: begin
            if (bus.abort) begin
               state_n = S_ERR;
            end else if (bus.wb_ack) begin
               if (last) begin
                  state_n = S_DONE;
               end else begin
                  idx_inc = 1'b1;
                  state_n = S_LOAD;
               end
            end else if (expired) begin
               state_n = S_ERR;
               ec_n    = EC_WB;
            end
         end
         state[I_DONE], state[I_ERR]: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Outputs are registered copies of the next-state decode.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ld_r       <= 1'b0;
         conv_r     <= 1'b0;
         wb_r       <= 1'b0;
         err_r      <= 1'b0;
         err_code_r <= EC_ABORT;
         num_lat    <= '0;
         tile_idx_r <= '0;
      end else begin
         state  <= state_n;
         ld_r   <= state_n == S_LOAD;
         conv_r <= state_n == S_CONV;
         wb_r   <= state_n == S_WB;
         done_r <= state_n == S_DONE;
         busy_r <= state_n inside {S_LOAD, S_CONV, S_DRAIN, S_WB};
         if (load_job) begin
            num_lat    <= bus.num_tiles;
            tile_idx_r <= '0;
            err_r      <= 1'b0;
            err_code_r <= EC_ABORT;
         end else if (idx_inc) begin
            tile_idx_r <= tile_idx_r + TILE_W'(1);
         end
         if (set_err) begin
            err_r      <= 1'b1;
            err_code_r <= ec_n;
         end
      end
   end

   // The engine's done flag from the previous tile lingers, so
   // conv_done is only trusted GUARD cycles into each CONV phase.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gcnt <= '0;
      end else if (wd_clr) begin
         gcnt <= '0;
      end else if (state[I_CONV] && !guard_ok) begin
         gcnt <= gcnt + GW'(1);
      end
   end

   assign bus.busy     = busy_r;
   assign bus.job_done = done_r;
   assign bus.err      = err_r;
   assign bus.err_code = err_code_r;
   assign bus.tile_idx = tile_idx_r;
   assign bus.ld_req   = ld_r;
   assign bus.conv_en  = conv_r;
   assign bus.wb_req   = wb_r;

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: table jobs, corner
// sequences and random jobs against a phase-level model.
module tb_conv_sched;
   import conv_sched_pkg::*;

   localparam int TW  = 8;
   localparam int TMO = 64;
   localparam int GRD = 2;

   typedef struct {
      int n;
      int l;
      int c;
      int w;
      int busy;
      int done;
      int err;
      int code;
      int nld;
      int nwb;
   } vec_t;

   typedef struct {
      int busy;
      int done;
      int err;
      int code;
      int nld;
      int nwb;
   } res_t;

   typedef struct {
      int busy;
      int done;
      int err;
      int code;
      int nld;
      int nwb;
      int idx;
      int ack_ab;
      int ovl;
   } obs_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   conv_sched_if #(.TILE_W(TW)) bus ();

   conv_sched #(
      .TILE_W  (TW),
      .TO_W    (16),
      .TIMEOUT (TMO),
      .GUARD   (GRD)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   ld_lat [256];
   int   cv_lat [256];
   int   wb_lat [256];
   int   lcnt   = 0;
   int   ecnt   = 0;
   int   wcnt   = 0;
   obs_t obs;
   vec_t tbl    [11];

   // DMA and engine responders; the engine's done flag is sticky
   // while disabled and stays stale for GRD cycles after enable.
   always @(negedge clk) begin
      if (!rstn) begin
         bus.ld_ack    = 1'b0;
         bus.wb_ack    = 1'b0;
         bus.conv_done = 1'b0;
         lcnt = 0;
         ecnt = 0;
         wcnt = 0;
      end else begin
         if (bus.ld_req) begin
            bus.ld_ack = lcnt >= ld_lat[bus.tile_idx];
            lcnt++;
         end else begin
            bus.ld_ack = 1'b0;
            lcnt = 0;
         end
         if (bus.conv_en) begin
            if (ecnt >= GRD)
               bus.conv_done = ecnt >= cv_lat[bus.tile_idx];
            ecnt++;
         end else begin
            ecnt = 0;
         end
         if (bus.wb_req) begin
            bus.wb_ack = wcnt >= wb_lat[bus.tile_idx];
            wcnt++;
         end else begin
            bus.wb_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({bus.busy, bus.job_done, bus.err, bus.err_code,
                   bus.tile_idx, bus.ld_req, bus.conv_en, bus.wb_req});
   endfunction

   task automatic set_lat(input int l, input int c, input int w);
      for (int i = 0; i < 256; i++) begin
         ld_lat[i] = l;
         cv_lat[i] = c;
         wb_lat[i] = w;
      end
   endtask

   // Phase arithmetic: a phase with latency k lasts k+1 cycles,
   // or times out after TMO cycles when k > TMO-1. Abort in busy
   // cycle a ends the job after a+1 busy cycles.
   function automatic res_t model(input int n, input int ab);
      res_t r;
      int   t;
      int   lat;
      int   d;
      bit   tmo;
      bit   stop;
      r    = '{default: 0};
      t    = 0;
      stop = 1'b0;
      if (n == 0) begin
         r.done = 1;
         return r;
      end
      for (int i = 0; i < n && !stop; i++) begin
         for (int p = 0; p < 4 && !stop; p++) begin
            lat = 0;
            if (p == 0) begin
               lat = ld_lat[i];
               r.nld++;
            end
            if (p == 1) lat = cv_lat[i];
            if (p == 3) begin
               lat = wb_lat[i];
               r.nwb++;
            end
            tmo = (p != 2) && (lat > TMO - 1);
            d   = tmo ? TMO : lat + 1;
            if (ab >= 0 && ab < t + d) begin
               r.busy = ab + 1;
               r.err  = 1;
               r.code = 0;
               stop   = 1'b1;
            end else if (tmo) begin
               r.busy = t + d;
               r.err  = 1;
               r.code = (p == 0) ? 1 : (p == 1) ? 2 : 3;
               stop   = 1'b1;
            end else begin
               t += d;
            end
         end
      end
      if (!stop) begin
         r.busy = t;
         r.done = 1;
      end
      return r;
   endfunction

   task automatic run_job(input int n, input int ab, input int rs,
                          input bit ab_st);
      int bidx;
      bit pld;
      bit pwb;
      bit ended;
      bidx  = 0;
      pld   = 1'b0;
      pwb   = 1'b0;
      ended = 1'b0;
      obs   = '{default: 0};
      bus.start     = 1'b1;
      bus.abort     = ab_st;
      bus.num_tiles = TW'(n);
      @(negedge clk);
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.num_tiles = TW'($urandom);
      for (int cyc = 0; cyc < 5000 && !ended; cyc++) begin
         if (bus.ld_req && !pld) begin
            chk("ld_tile", int'(bus.tile_idx), obs.nld);
            obs.nld++;
         end
         if (bus.wb_req && !pwb) begin
            chk("wb_tile", int'(bus.tile_idx), obs.nwb);
            obs.nwb++;
         end
         if (int'(bus.ld_req) + int'(bus.conv_en)
             + int'(bus.wb_req) > 1)
            obs.ovl++;
         pld       = bus.ld_req;
         pwb       = bus.wb_req;
         bus.start = 1'b0;
         bus.abort = 1'b0;
         if (bus.busy) begin
            if (bidx == rs) begin
               bus.start     = 1'b1;
               bus.num_tiles = TW'(9);
            end
            if (bidx == ab) begin
               bus.abort = 1'b1;
               #1 obs.ack_ab = int'(bus.wb_ack);
            end
            bidx++;
         end
         if (bus.job_done) obs.done++;
         if (bus.job_done || bus.err) begin
            ended    = 1'b1;
            obs.err  = int'(bus.err);
            obs.code = int'(bus.err_code);
            obs.idx  = int'(bus.tile_idx);
         end else begin
            @(negedge clk);
         end
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      obs.busy  = bidx;
      if (!ended) begin
         checks++;
         errors++;
         $display("FAIL job_end: no done/err within bound, n=%0d", n);
      end else begin
         @(negedge clk);
         chk("done_pulse", int'(bus.job_done), 0);
         chk("busy_after", int'(bus.busy), 0);
      end
   endtask

   task automatic compare(input string tg, input res_t e);
      chk({tg, "_busy"}, obs.busy, e.busy);
      chk({tg, "_done"}, obs.done, e.done);
      chk({tg, "_err"}, obs.err, e.err);
      if (e.err != 0) chk({tg, "_code"}, obs.code, e.code);
      chk({tg, "_nld"}, obs.nld, e.nld);
      chk({tg, "_nwb"}, obs.nwb, e.nwb);
      chk({tg, "_ovl"}, obs.ovl, 0);
   endtask

   initial begin
      res_t e;
      int   n;
      int   ab;
      int   k;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.num_tiles = '0;
      //           n   l   c    w   busy dn er cd nld nwb
      tbl[0]  = '{  1,  3,  40,  2,   49, 1, 0, 0,  1,  1};
      tbl[1]  = '{  3,  0,   5,  0,   27, 1, 0, 0,  3,  3};
      tbl[2]  = '{  0,  0,   2,  0,    0, 1, 0, 0,  0,  0};
      tbl[3]  = '{  1,  1,1000,  0,   66, 0, 1, 2,  1,  0};
      tbl[4]  = '{  1,  0,   2,  0,    6, 1, 0, 0,  1,  1};
      tbl[5]  = '{  1, 63,   2,  0,   69, 1, 0, 0,  1,  1};
      tbl[6]  = '{  1, 64,   2,  0,   64, 0, 1, 1,  1,  0};
      tbl[7]  = '{  2,  0,   3,200,   70, 0, 1, 3,  1,  1};
      tbl[8]  = '{  2,  1,  10,  1,   32, 1, 0, 0,  2,  2};
      tbl[9]  = '{255,  0,   2,  0, 1530, 1, 0, 0,255,255};
      tbl[10] = '{  1,  0,  62,  1,   67, 1, 0, 0,  1,  1};

      #1 rstn = 1'b0;
      #10 chk("reset_outs", outs(), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         set_lat(tbl[i].l, tbl[i].c, tbl[i].w);
         run_job(tbl[i].n, -1, -1, 1'b0);
         e = '{tbl[i].busy, tbl[i].done, tbl[i].err,
               tbl[i].code, tbl[i].nld, tbl[i].nwb};
         compare($sformatf("tbl%0d", i), e);
         @(negedge clk);
      end

      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("idle_abort_busy", int'(bus.busy), 0);
      chk("idle_abort_err", int'(bus.err), 0);

      set_lat(0, 2, 0);
      run_job(1, -1, -1, 1'b1);
      compare("start_abort", model(1, -1));

      set_lat(0, 3, 2);
      run_job(2, 8, 1, 1'b0);
      compare("abort_wb", model(2, 8));
      chk("abort_wb_ack", obs.ack_ab, 1);
      chk("abort_wb_idx", obs.idx, 0);
      @(negedge clk);

      set_lat(0, 1000, 0);
      bus.num_tiles = TW'(2);
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!bus.conv_en && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rst_conv_seen", int'(bus.conv_en), 1);
      @(negedge clk);
      #1 rstn = 1'b0;
      #1 chk("async_reset", outs(), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      set_lat(1, 3, 1);
      run_job(2, -1, -1, 1'b0);
      compare("after_rst", model(2, -1));

      for (int j = 0; j < 25; j++) begin
         n = $urandom_range(0, 4);
         for (int i = 0; i < 256; i++) begin
            ld_lat[i] = ($urandom_range(0, 9) == 0)
                        ? 70 : $urandom_range(0, 6);
            cv_lat[i] = ($urandom_range(0, 9) == 0)
                        ? 80 : $urandom_range(GRD, 12);
            wb_lat[i] = ($urandom_range(0, 9) == 0)
                        ? 70 : $urandom_range(0, 6);
         end
         ab = ($urandom_range(0, 3) == 0)
              ? $urandom_range(0, 40) : -1;
         e = model(n, ab);
         run_job(n, ab, -1, 1'b0);
         compare($sformatf("rnd%0d", j), e);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
